// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-stated data memory responder.
package dmem_pkg;
  localparam int BE_W      = 4;
  localparam int WORD_W    = 32;
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  // Misaligned byte address or word index past the end of the array.
  function automatic logic addr_err(input logic [WORD_W-1:0] a, input logic [31:0] depth);
    return (a[1:0] != 2'b00) || ({2'b00, a[WORD_W-1:2]} >= depth);
  endfunction
endpackage

// File: rtl/dmem_bank.sv
// Word array split into byte lanes; synchronous per-lane write, combinational read.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);
  for (genvar l = 0; l < BE_W; l++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (we_i && be_i[l]) lane_mem[idx_i] <= wdata_i[8*l +: 8];
    end

    assign rdata_o[8*l +: 8] = lane_mem[idx_i];
  end
endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated, word-addressed data memory answering one load/store at a time.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e                state_q, state_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  req_t                  req_q, req_d;
  logic [WORD_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  commit, err, bank_we;
  logic [WORD_W-1:0]     bank_rdata;

  // WAIT always runs LATENCY+1 cycles (cnt counts down to zero) so the
  // response appears LATENCY+1 cycles after acceptance, LATENCY=0 included.
  assign commit = (state_q == ST_WAIT) && (cnt_q == '0);
  assign err    = addr_err(req_q.addr, 32'(DEPTH_WORDS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    busy      = (state_q != ST_IDLE);
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
  end

  always_comb begin
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    bank_we     = 1'b0;
    if (state_q == ST_IDLE && req_valid) begin
      req_d = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
      cnt_d = LAT_CNT_W'(LATENCY);
    end
    if (state_q == ST_WAIT && cnt_q != '0) cnt_d = cnt_q - 1'b1;
    if (commit) begin
      bank_we     = req_q.we && !err;
      rsp_err_d   = err;
      rsp_rdata_d = (!req_q.we && !err) ? bank_rdata : '0;
    end
    if (state_q == ST_RESP && rsp_ready) rsp_err_d = 1'b0;
  end

  dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_bank (
    .clk     (clk),
    .we_i    (bank_we),
    .be_i    (req_q.be),
    .idx_i   (req_q.addr[IDX_W+1:2]),
    .wdata_i (req_q.wdata),
    .rdata_o (bank_rdata)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus pushes expected responses, a monitor pops on each handshake.
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  int          tests = 0, fails = 0;
  int          cyc = 0, accept_cyc = 0, rsp_count = 0;
  bit          lat_armed = 0;
  logic        prev_valid = 1'b0;
  logic [32:0] exp_q[$];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: latency of each rising rsp_valid and payload of each handshake.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      if (rsp_valid && !prev_valid && lat_armed) begin
        check("latency", 32'(cyc - accept_cyc), 32'(LAT + 1));
        lat_armed = 0;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: got rdata %h err %b expected none", rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e[31:0]);
          check("rsp_err", 32'(rsp_err), 32'(e[32]));
        end
      end
    end
    prev_valid = rsp_valid;
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit push,
                       input logic [31:0] erd, input logic eerr);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL issue_timeout: got req_ready %b expected 1", req_ready);
      return;
    end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    if (push) exp_q.push_back({eerr, erd});
    accept_cyc = cyc + 1;
    lat_armed  = 1;
    @(posedge clk); #1;
    // Scramble sideband after acceptance; the DUT must ignore it.
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_be = 4'hF;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL done_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic wait_rsp_valid();
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: got rsp_valid %b expected 1", rsp_valid);
    end
  endtask

  initial begin
    logic [31:0] held;
    int c0;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Full store then load back.
    issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0, 0);          wait_done();
    issue(0, 32'h10, 32'h0,        4'h0, 1, 32'hDEADBEEF, 0);   wait_done();
    // Byte-lane store merges into the existing word.
    issue(1, 32'h10, 32'h000000AA, 4'b0001, 1, 32'h0, 0);       wait_done();
    issue(0, 32'h10, 32'h0,        4'hF, 1, 32'hDEADBEAA, 0);   wait_done();
    // Error cases never touch the array.
    issue(0, 32'h12, 32'h0, 4'hF, 1, 32'h0, 1);                 wait_done();
    issue(0, DEPTH*4, 32'h0, 4'hF, 1, 32'h0, 1);                wait_done();
    issue(1, 32'h11, 32'h55555555, 4'hF, 1, 32'h0, 1);          wait_done();
    issue(1, 32'h10, 32'hFFFFFFFF, 4'h0, 1, 32'h0, 0);          wait_done();
    issue(0, 32'h10, 32'h0, 4'hF, 1, 32'hDEADBEAA, 0);          wait_done();

    // Back-pressure: response held stable while rsp_ready is low.
    rsp_ready = 1'b0;
    issue(0, 32'h10, 32'h0, 4'hF, 1, 32'hDEADBEAA, 0);
    wait_rsp_valid();
    held = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, held);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    check("pre_hs_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("post_hs_req_ready", 32'(req_ready), 32'd1);
    check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    wait_done();

    // Async reset while a response is pending discards it.
    rsp_ready = 1'b0;
    issue(0, 32'h10, 32'h0, 4'hF, 0, 32'h0, 0);
    wait_rsp_valid();
    #2 rst = 1'b0;
    #1;
    check("mid_rsp_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rsp_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rsp_rst_busy", 32'(busy), 32'd0);
    check("mid_rsp_rst_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk); rst = 1'b1;

    // Reset during WAIT drops a store: old word survives, one response total.
    issue(1, 32'h20, 32'hCAFEF00D, 4'hF, 1, 32'h0, 0);          wait_done();
    c0 = rsp_count;
    issue(1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0, 0);
    check("wait_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1 check("wait_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b1;
    issue(0, 32'h20, 32'h0, 4'hF, 1, 32'hCAFEF00D, 0);          wait_done();
    check("rsp_count", 32'(rsp_count - c0), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
